// File: rtl/calc1_port_driver_if.sv
// Signal bundle between the sequencer, the calc1 port driver and the calc1 port.
// The master modport is the driver's view; slave is the environment's view.
interface calc1_port_driver_if;
  logic        txn_valid;
  logic        txn_ready;
  logic [0:3]  txn_cmd;
  logic [0:31] txn_op1;
  logic [0:31] txn_op2;
  logic [0:3]  req_cmd_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        res_valid;
  logic [0:1]  res_resp;
  logic [0:31] res_data;
  logic        res_timeout;
  logic        proto_err;

  modport master (
    input  txn_valid, txn_cmd, txn_op1, txn_op2, out_resp, out_data,
    output txn_ready, req_cmd_in, req_data_in, res_valid, res_resp, res_data, res_timeout,
           proto_err
  );

  modport slave (
    output txn_valid, txn_cmd, txn_op1, txn_op2, out_resp, out_data,
    input  txn_ready, req_cmd_in, req_data_in, res_valid, res_resp, res_data, res_timeout,
           proto_err
  );
endinterface

// File: rtl/calc1_port_driver.sv
// Drives one calc1 transaction at a time: command+op1, then op2, then waits for a response
// (or gives up after TIMEOUT WAIT cycles) and presents the result for one cycle.
module calc1_port_driver #(
  parameter int unsigned TIMEOUT = 31
) (
  input logic                 c_clk,
  input logic                 reset_n,
  calc1_port_driver_if.master bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSend1 = 3'd1;
  localparam logic [2:0] StSend2 = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [2:0]  r_state;
  logic [7:0]  r_cnt;
  logic [0:3]  r_cmd;
  logic [0:31] r_op1;
  logic [0:31] r_op2;
  logic [0:1]  r_res_resp;
  logic [0:31] r_res_data;
  logic        r_res_timeout;
  logic        r_proto_err;

  logic [2:0]  w_state_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_accept;
  logic        w_capture;
  logic        w_expire;
  logic        w_resp_seen;

  assign w_resp_seen = (bus.out_resp != 2'd0);
  assign w_accept    = (r_state == StIdle) && bus.txn_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      StIdle:  if (bus.txn_valid) w_state_nxt = StSend1;
      StSend1: w_state_nxt = StSend2;
      StSend2: begin
        w_state_nxt = StWait;
        w_cnt_nxt   = 8'd0;
      end
      StWait: begin
        // A response on the expiry edge still counts as a real result.
        if (w_resp_seen) begin
          w_capture   = 1'b1;
          w_state_nxt = StDone;
        end else if (r_cnt == TimeoutLast) begin
          w_expire    = 1'b1;
          w_state_nxt = StDone;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_cnt         <= 8'd0;
      r_cmd         <= '0;
      r_op1         <= '0;
      r_op2         <= '0;
      r_res_resp    <= '0;
      r_res_data    <= '0;
      r_res_timeout <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_cmd <= bus.txn_cmd;
        r_op1 <= bus.txn_op1;
        r_op2 <= bus.txn_op2;
      end
      if (w_capture) begin
        r_res_resp    <= bus.out_resp;
        r_res_data    <= bus.out_data;
        r_res_timeout <= 1'b0;
      end else if (w_expire) begin
        r_res_resp    <= '0;
        r_res_data    <= '0;
        r_res_timeout <= 1'b1;
      end
      if (r_state != StWait && w_resp_seen) r_proto_err <= 1'b1;
    end
  end

  assign bus.txn_ready   = (r_state == StIdle);
  assign bus.req_cmd_in  = (r_state == StSend1) ? r_cmd : 4'd0;
  assign bus.req_data_in = (r_state == StSend1) ? r_op1 :
                           (r_state == StSend2) ? r_op2 : 32'd0;
  assign bus.res_valid   = (r_state == StDone);
  assign bus.res_resp    = r_res_resp;
  assign bus.res_data    = r_res_data;
  assign bus.res_timeout = r_res_timeout;
  assign bus.proto_err   = r_proto_err;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Bench for calc1_port_driver: two instances (TIMEOUT=4 and TIMEOUT=2) share one stimulus;
// sel_b picks whose outputs are observed. Expected results come from a latency/timeout model.
module tb_calc1_port_driver;

  logic c_clk = 1'b0;
  logic reset_n;
  logic sel_b = 1'b0;
  always #5 c_clk = ~c_clk;

  calc1_port_driver_if ifa();
  calc1_port_driver_if ifb();

  calc1_port_driver #(.TIMEOUT(4)) u_dut_a (.c_clk(c_clk), .reset_n(reset_n), .bus(ifa));
  calc1_port_driver #(.TIMEOUT(2)) u_dut_b (.c_clk(c_clk), .reset_n(reset_n), .bus(ifb));

  assign ifb.txn_valid = ifa.txn_valid;
  assign ifb.txn_cmd   = ifa.txn_cmd;
  assign ifb.txn_op1   = ifa.txn_op1;
  assign ifb.txn_op2   = ifa.txn_op2;
  assign ifb.out_resp  = ifa.out_resp;
  assign ifb.out_data  = ifa.out_data;

  logic        o_ready, o_valid, o_to, o_perr;
  logic [0:3]  o_cmd;
  logic [0:31] o_data, o_rdata;
  logic [0:1]  o_resp;
  assign o_ready = sel_b ? ifb.txn_ready   : ifa.txn_ready;
  assign o_valid = sel_b ? ifb.res_valid   : ifa.res_valid;
  assign o_to    = sel_b ? ifb.res_timeout : ifa.res_timeout;
  assign o_perr  = sel_b ? ifb.proto_err   : ifa.proto_err;
  assign o_cmd   = sel_b ? ifb.req_cmd_in  : ifa.req_cmd_in;
  assign o_data  = sel_b ? ifb.req_data_in : ifa.req_data_in;
  assign o_rdata = sel_b ? ifb.res_data    : ifa.res_data;
  assign o_resp  = sel_b ? ifb.res_resp    : ifa.res_resp;

  int checks = 0;
  int errors = 0;

  logic [0:1]  prev_resp;
  logic [0:31] prev_data;
  logic        prev_to;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge c_clk);
    reset_n       = 1'b0;
    ifa.txn_valid = 1'b0;
    ifa.out_resp  = 2'd0;
    ifa.out_data  = 32'd0;
    repeat (2) @(negedge c_clk);
    reset_n   = 1'b1;
    prev_resp = 2'd0;
    prev_data = 32'd0;
    prev_to   = 1'b0;
  endtask

  // d = WAIT cycle (1-based) in which the port answers; 0 = never answers.
  task automatic run_txn(input logic [0:3] cmd, input logic [0:31] op1, input logic [0:31] op2,
                         input int d, input logic [0:1] resp, input logic [0:31] rdata,
                         input bit hold, input int max_wait);
    int          t;
    bit          tmo;
    int          eff;
    int          waits;
    logic [0:1]  exp_resp;
    logic [0:31] exp_data;
    t        = sel_b ? 2 : 4;
    tmo      = (d == 0) || (d > t);
    eff      = tmo ? t : d;
    exp_resp = tmo ? 2'd0 : resp;
    exp_data = tmo ? 32'd0 : rdata;

    @(negedge c_clk);
    checks++;
    if (o_valid !== 1'b0 || o_resp !== prev_resp || o_rdata !== prev_data || o_to !== prev_to) begin
      errors++;
      $display("FAIL idle_hold: got v=%0b r=%0h d=%0h t=%0b want v=0 r=%0h d=%0h t=%0b",
               o_valid, o_resp, o_rdata, o_to, prev_resp, prev_data, prev_to);
    end
    ifa.txn_cmd   = cmd;
    ifa.txn_op1   = op1;
    ifa.txn_op2   = op2;
    ifa.txn_valid = 1'b1;
    waits = 0;
    while (o_ready !== 1'b1 && waits < max_wait) begin
      @(negedge c_clk);
      waits++;
    end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: got %0b want 1", o_ready);
    end

    @(negedge c_clk);
    if (!hold) ifa.txn_valid = 1'b0;
    checks++;
    if (o_cmd !== cmd || o_data !== op1 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL send1: got cmd=%0h data=%0h rdy=%0b want cmd=%0h data=%0h rdy=0",
               o_cmd, o_data, o_ready, cmd, op1);
    end

    @(negedge c_clk);
    checks++;
    if (o_cmd !== 4'd0 || o_data !== op2) begin
      errors++;
      $display("FAIL send2: got cmd=%0h data=%0h want cmd=0 data=%0h", o_cmd, o_data, op2);
    end

    for (int k = 1; k <= eff; k++) begin
      @(negedge c_clk);
      checks++;
      if (o_valid !== 1'b0 || o_cmd !== 4'd0 || o_data !== 32'd0) begin
        errors++;
        $display("FAIL wait%0d: got v=%0b cmd=%0h data=%0h want v=0 cmd=0 data=0",
                 k, o_valid, o_cmd, o_data);
      end
      if (k == d) begin
        ifa.out_resp = resp;
        ifa.out_data = rdata;
      end else begin
        ifa.out_resp = 2'd0;
        ifa.out_data = $urandom;
      end
    end

    @(negedge c_clk);
    ifa.out_resp = 2'd0;
    ifa.out_data = 32'd0;
    checks++;
    if (o_valid !== 1'b1 || o_resp !== exp_resp || o_rdata !== exp_data || o_to !== tmo ||
        o_ready !== 1'b0) begin
      errors++;
      $display("FAIL done: got v=%0b r=%0h d=%0h t=%0b rdy=%0b want v=1 r=%0h d=%0h t=%0b rdy=0",
               o_valid, o_resp, o_rdata, o_to, o_ready, exp_resp, exp_data, tmo);
    end
    prev_resp = exp_resp;
    prev_data = exp_data;
    prev_to   = tmo;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    ifa.txn_valid = 1'b0;
    ifa.txn_cmd   = 4'd0;
    ifa.txn_op1   = 32'd0;
    ifa.txn_op2   = 32'd0;
    ifa.out_resp  = 2'd0;
    ifa.out_data  = 32'd0;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_cmd !== 4'd0 || o_data !== 32'd0 ||
        o_resp !== 2'd0 || o_rdata !== 32'd0 || o_to !== 1'b0 || o_perr !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%0b v=%0b cmd=%0h d=%0h r=%0h rd=%0h t=%0b pe=%0b want 1,0,0,0,0,0,0,0",
               o_ready, o_valid, o_cmd, o_data, o_resp, o_rdata, o_to, o_perr);
    end
    repeat (2) @(negedge c_clk);
    reset_n   = 1'b1;
    prev_resp = 2'd0;
    prev_data = 32'd0;
    prev_to   = 1'b0;
  endtask

  task automatic test_add();
    run_txn(4'd1, 32'd5, 32'd7, 3, 2'd1, 32'd12, 1'b0, 4);
  endtask

  task automatic test_timeout();
    run_txn(4'd2, 32'd100, 32'd1, 0, 2'd1, 32'd0, 1'b0, 4);
    run_txn(4'd6, 32'hdead, 32'h2, 5, 2'd1, 32'h1234, 1'b0, 4);
  endtask

  task automatic test_back_to_back();
    run_txn(4'd2, 32'd9, 32'd4, 1, 2'd1, 32'd5, 1'b1, 4);
    run_txn(4'd5, 32'd1, 32'd3, 2, 2'd1, 32'd8, 1'b0, 0);
  endtask

  task automatic test_spurious();
    @(negedge c_clk);
    ifa.out_resp = 2'd2;
    @(negedge c_clk);
    ifa.out_resp = 2'd0;
    checks++;
    if (o_perr !== 1'b1) begin
      errors++;
      $display("FAIL proto_err_set: got %0b want 1", o_perr);
    end
    run_txn(4'd1, 32'd20, 32'd22, 2, 2'd1, 32'd42, 1'b0, 4);
    @(negedge c_clk);
    checks++;
    if (o_perr !== 1'b1) begin
      errors++;
      $display("FAIL proto_err_sticky: got %0b want 1", o_perr);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit saw_valid;
    @(negedge c_clk);
    ifa.txn_cmd   = 4'd1;
    ifa.txn_op1   = 32'd3;
    ifa.txn_op2   = 32'd4;
    ifa.txn_valid = 1'b1;
    @(negedge c_clk);
    ifa.txn_valid = 1'b0;
    repeat (3) @(negedge c_clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_cmd !== 4'd0 || o_data !== 32'd0 ||
        o_resp !== 2'd0 || o_rdata !== 32'd0 || o_to !== 1'b0 || o_perr !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: got rdy=%0b v=%0b cmd=%0h d=%0h r=%0h rd=%0h t=%0b pe=%0b want 1,0,0,0,0,0,0,0",
               o_ready, o_valid, o_cmd, o_data, o_resp, o_rdata, o_to, o_perr);
    end
    ifa.out_resp = 2'd1;
    ifa.out_data = 32'd99;
    saw_valid = 1'b0;
    repeat (2) begin
      @(negedge c_clk);
      if (o_valid !== 1'b0) saw_valid = 1'b1;
    end
    reset_n      = 1'b1;
    ifa.out_resp = 2'd0;
    ifa.out_data = 32'd0;
    @(posedge c_clk);
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %0b want 1", o_ready);
    end
    repeat (6) begin
      @(negedge c_clk);
      if (o_valid !== 1'b0) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_valid_after_reset: got %0b want 0", saw_valid);
    end
    prev_resp = 2'd0;
    prev_data = 32'd0;
    prev_to   = 1'b0;
  endtask

  task automatic test_boundary();
    sel_b = 1'b1;
    do_reset();
    run_txn(4'd3, 32'h11, 32'h22, 2, 2'd3, 32'hcafe, 1'b0, 4);
    run_txn(4'd4, 32'h33, 32'h44, 3, 2'd1, 32'hbeef, 1'b0, 4);
    run_txn(4'd1, 32'h55, 32'h66, 1, 2'd2, 32'h7777, 1'b0, 4);
    sel_b = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge c_clk);
      run_txn(4'($urandom), $urandom, $urandom, int'($urandom_range(0, 6)),
              2'($urandom_range(1, 3)), $urandom, 1'b0, 4);
    end
    @(negedge c_clk);
    checks++;
    if (o_perr !== 1'b0) begin
      errors++;
      $display("FAIL no_proto_err: got %0b want 0", o_perr);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_timeout();
    test_back_to_back();
    test_spurious();
    test_reset_mid_wait();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc1_port_driver.md
CALC1_PORT_DRIVER -- requirements
Module: calc1_port_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 31: WAIT-state cycles allowed before a transaction is abandoned; legal range 1..255.
REQ-002 SHALL have port c_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port txn_valid, input, 1 bit: sequencer offers a transaction.
REQ-005 SHALL have port txn_ready, output, 1 bit: driver accepts a transaction this cycle.
REQ-006 SHALL have port txn_cmd, input, 4 bits [0:3]: calc1 command code.
REQ-007 SHALL have ports txn_op1 and txn_op2, input, 32 bits each [0:31]: operands 1 and 2.
REQ-008 SHALL have port req_cmd_in, output, 4 bits [0:3]: command to the calc1 port.
REQ-009 SHALL have port req_data_in, output, 32 bits [0:31]: operand data to the calc1 port.
REQ-010 SHALL have port out_resp, input, 2 bits [0:1]: calc1 response (0 none, 1 success, 2 invalid/overflow, 3 internal error).
REQ-011 SHALL have port out_data, input, 32 bits [0:31]: calc1 result data.
REQ-012 SHALL have port res_valid, output, 1 bit: one-cycle pulse when a result is presented.
REQ-013 SHALL have ports res_resp (2 bits) and res_data (32 bits), outputs: captured response and data.
REQ-014 SHALL have port res_timeout, output, 1 bit: qualifies res_valid; 1 means no response arrived within TIMEOUT.
REQ-015 SHALL have port proto_err, output, 1 bit: sticky flag for a response seen when none is outstanding.

Function
REQ-016 SHALL implement states IDLE, SEND1, SEND2, WAIT, DONE; register only, no combinational input-to-output paths except txn_ready.
REQ-017 SHALL assert txn_ready only in IDLE; txn_valid and txn_ready both high at a rising edge capture cmd/op1/op2 and move to SEND1.
REQ-018 In SEND1, SHALL drive req_cmd_in=captured cmd and req_data_in=op1 for exactly one cycle, then go to SEND2.
REQ-019 In SEND2, SHALL drive req_cmd_in=0 and req_data_in=op2 for exactly one cycle, then go to WAIT with the wait counter cleared.
REQ-020 In IDLE, WAIT and DONE, SHALL drive req_cmd_in=0 and req_data_in=0.
REQ-021 In WAIT, SHALL sample out_resp each rising edge; nonzero captures out_resp into res_resp and out_data into res_data, clears res_timeout, and goes to DONE.
REQ-022 In WAIT with out_resp=0, SHALL increment an 8-bit counter; when the counter equals TIMEOUT-1 at an edge, SHALL go to DONE with res_timeout=1, res_resp=0, res_data=0.
REQ-023 A response arriving on the same edge as the timeout SHALL win: captured as a normal result, res_timeout=0.
REQ-024 In DONE, SHALL assert res_valid for exactly one cycle, then return to IDLE; res_resp/res_data/res_timeout SHALL hold until the next DONE.
REQ-025 SHALL pass txn_cmd unchanged, including invalid codes; checking belongs to the DUV.
REQ-026 Nonzero out_resp sampled in IDLE, SEND1, SEND2 or DONE SHALL set proto_err, which stays set until reset; the FSM is unaffected.
REQ-027 Minimum accept-to-res_valid latency SHALL be 4 cycles (SEND1, SEND2, one WAIT, DONE); back-to-back throughput is one transaction per latency+1 cycles.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, counter 0, req_cmd_in=0, req_data_in=0, res_valid=0, res_resp=0, res_data=0, res_timeout=0, proto_err=0.
REQ-029 Reset mid-transaction SHALL discard it silently with no res_valid; txn_ready=1 on the first edge after release.

Verification
REQ-030 Add: cmd=1, op1=5, op2=7; DUV returns resp=1, data=12 on the 3rd WAIT cycle -> req_cmd_in=1/data=5, then cmd=0/data=7, then res_valid pulse with res_resp=1, res_data=12, res_timeout=0.
REQ-031 Timeout: TIMEOUT=4, out_resp held 0 -> res_valid 4 cycles after entering WAIT, with res_timeout=1, res_resp=0, res_data=0.
REQ-032 Back-to-back: txn_valid held high with two transactions (sub 9-4, shift-left 1<<3) -> second accepted the cycle after the first DONE; results 5 and 8 in order.
REQ-033 Reset mid-WAIT: assert reset_n low during WAIT -> outputs zero immediately, no res_valid, txn_ready=1 after release.
REQ-034 Spurious response: out_resp=2 in IDLE -> proto_err=1 and stays set through a subsequent normal transaction, cleared only by reset.
REQ-035 Boundary: response on the same edge as timeout (TIMEOUT=2, resp=3 on the 2nd WAIT cycle) -> res_resp=3, res_timeout=0.
